matmul_seq: RTL and testbench
=============================

# matmul_seq

- Controller that sequences one DIM x DIM systolic multiply over the skewed operand memories (memA, and memB on the same port pattern) and the PE array.
- Runs in three stages:
  - accepts DIM operand rows from upstream over a valid/ready handshake and writes each into the memories by row index;
  - enables the memories to shift out their skewed columns for exactly 3*DIM-2 cycles;
  - drains the array and pulses done.
- Sits between the host/DMA row source and the memA/memB/systolic-array datapath. It passes row data through and owns every enable.

## Interface
- BITS_AB, 8, operand element width (signed).
- DIM, 8, array dimension; rows per operand matrix.
- DRAIN, 2, cycles the array stays enabled after the memories stop shifting.
- ROWBITS (localparam), $clog2(DIM).
- CNTBITS (localparam), $clog2(3*DIM-2+DRAIN).

- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new multiply; sampled only in IDLE.
- abort  in  1  synchronous cancel; return to IDLE, no done.
- in_valid  in  1  upstream row valid.
- in_ready  out  1  controller accepts a row this cycle.
- in_a  in  signed [BITS_AB-1:0] x DIM  A row data.
- in_b  in  signed [BITS_AB-1:0] x DIM  B row data.
- Ain / Bin  out  signed [BITS_AB-1:0] x DIM  combinational pass-through of in_a / in_b.
- mem_wr_en  out  1  write strobe to memA/memB (WrEn).
- mem_row  out  ROWBITS  row index for the write (Arow/Brow).
- mem_en  out  1  shift enable to memA/memB (en).
- sys_en  out  1  systolic array enable.
- sys_clr  out  1  clear PE accumulators.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- State register encodes IDLE, CLEAR, LOAD, COMPUTE, DRAIN, DONE.
- Row counter: ROWBITS wide. Cycle counter: CNTBITS wide.
- All outputs except Ain, Bin and mem_wr_en are decoded from registered state only (Moore).
- IDLE:
  - All outputs 0 except pass-through.
  - start=1 → CLEAR.
- CLEAR:
  - sys_clr=1 for exactly one cycle; row counter ← 0.
  - → LOAD.
- LOAD:
  - in_ready=1.
  - mem_wr_en = in_valid & in_ready (combinational); mem_row = row counter.
  - Each handshake increments the row counter.
  - Handshake on row DIM-1 → COMPUTE, cycle counter ← 0.
  - in_valid low stalls with no side effects.
- COMPUTE:
  - mem_en=1, sys_en=1; cycle counter increments every cycle.
  - At count 3*DIM-3 → DRAIN, counter ← 0.
- DRAIN:
  - sys_en=1, mem_en=0.
  - At count DRAIN-1 → DONE.
  - DRAIN=0 is legal: COMPUTE → DONE directly.
- DONE:
  - done=1, busy=1 for one cycle.
  - → IDLE unconditionally.
- abort=1 in any non-IDLE state → IDLE next edge. Abort has priority over every other transition, including the final-row handshake. No done is issued.
- start outside IDLE is ignored, including in the DONE cycle. A back-to-back start must arrive in IDLE.
- Counters never wrap within a transaction. The row counter wraps to 0 only via CLEAR.

## Timing
- Reset (async assert):
  - state=IDLE, counters=0.
  - in_ready, mem_wr_en, mem_row, mem_en, sys_en, sys_clr, busy, done all 0 immediately.
  - Deassertion takes effect at the next posedge.
- Reset mid-operation abandons the transaction. The memories keep partial contents; the next CLEAR/LOAD overwrites them.
- Start sampled at edge E0: CLEAR during E0–E1, LOAD from E1.
- With in_valid held high, rows 0..DIM-1 are accepted at E2..E(DIM+1).
- COMPUTE lasts E(DIM+1) to E(4*DIM-1): exactly 3*DIM-2 cycles of mem_en.
- DRAIN lasts DRAIN cycles. done is high during E(4*DIM-1+DRAIN) to E(4*DIM+DRAIN). IDLE follows.
- For DIM=8, DRAIN=2: mem_en high 22 cycles; done high in the cycle starting at E33.
- Each cycle of in_valid=0 during LOAD delays every subsequent event by one cycle.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 mid-COMPUTE (async, between edges).
  - Response: mem_en, sys_en and busy drop immediately; after release, start runs a full clean transaction.
- Nominal (DIM=8, DRAIN=2, in_valid constant):
  - mem_row 0..7 with mem_wr_en at E2..E9.
  - sys_clr only in E0–E1.
  - mem_en exactly 22 cycles.
  - done a single pulse at E33.
  - Ain equals in_a on every write.
- Gapped load:
  - Stimulus: deassert in_valid for 3 cycles after row 4.
  - Response: no mem_wr_en during the gap; rows stay 0..7 in order; done moves to E36.
- Abort:
  - Stimulus: abort at COMPUTE cycle 10.
  - Response: IDLE next edge; mem_en=0; done never asserts. A fresh start completes normally.
- start while busy:
  - Stimulus: pulse start during LOAD and again during the DONE cycle.
  - Response: both ignored. Exactly one done; controller sits in IDLE afterwards.
- DRAIN=0 build:
  - Response: done immediately follows the 22nd mem_en cycle; sys_en never high without mem_en.

Source files
------------

// File: rtl/matmul_seq.sv
// ============================================================================
// Module  : matmul_seq
// Purpose : Sequencer for one DIM x DIM systolic multiply (load, shift, drain).
// Revision: 1.0
// ============================================================================
`default_nettype none

module matmul_seq #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8,
    parameter int DRAIN   = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [DIM-1:0][BITS_AB-1:0] in_a,
    input  logic signed [DIM-1:0][BITS_AB-1:0] in_b,
    output logic signed [DIM-1:0][BITS_AB-1:0] Ain,
    output logic signed [DIM-1:0][BITS_AB-1:0] Bin,
    output logic                             mem_wr_en,
    output logic [$clog2(DIM)-1:0]           mem_row,
    output logic                             mem_en,
    output logic                             sys_en,
    output logic                             sys_clr,
    output logic                             busy,
    output logic                             done
);

    localparam int ROWBITS = $clog2(DIM);
    localparam int CNTBITS = $clog2(3*DIM-2+DRAIN);

    localparam logic [ROWBITS-1:0] LAST_ROW     = ROWBITS'(DIM-1);
    localparam logic [CNTBITS-1:0] LAST_COMPUTE = CNTBITS'(3*DIM-3);
    localparam logic [CNTBITS-1:0] LAST_DRAIN   = CNTBITS'((DRAIN > 0) ? DRAIN-1 : 0);
    localparam bit                 HAS_DRAIN    = (DRAIN > 0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic [ROWBITS-1:0] row_cnt, row_nxt;
    logic [CNTBITS-1:0] cyc_cnt, cyc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            row_cnt <= '0;
            cyc_cnt <= '0;
        end else begin
            state   <= state_nxt;
            row_cnt <= row_nxt;
            cyc_cnt <= cyc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row_cnt;
        cyc_nxt   = cyc_cnt;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                row_nxt   = '0;
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (in_valid) begin
                    // The last row holds the counter so it never wraps mid-transaction.
                    if (row_cnt == LAST_ROW) begin
                        cyc_nxt   = '0;
                        state_nxt = ST_COMPUTE;
                    end else begin
                        row_nxt = row_cnt + 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                if (cyc_cnt == LAST_COMPUTE) begin
                    cyc_nxt   = '0;
                    state_nxt = HAS_DRAIN ? ST_DRAIN : ST_DONE;
                end else begin
                    cyc_nxt = cyc_cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cyc_cnt == LAST_DRAIN) state_nxt = ST_DONE;
                else                       cyc_nxt   = cyc_cnt + 1'b1;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Abort overrides everything, including the final-row handshake.
        if (abort && (state != ST_IDLE)) state_nxt = ST_IDLE;
    end

    always_comb begin
        in_ready = 1'b0;
        mem_row  = '0;
        mem_en   = 1'b0;
        sys_en   = 1'b0;
        sys_clr  = 1'b0;
        busy     = (state != ST_IDLE);
        done     = 1'b0;
        case (state)
            ST_CLEAR:   sys_clr = 1'b1;
            ST_LOAD: begin
                in_ready = 1'b1;
                mem_row  = row_cnt;
            end
            ST_COMPUTE: begin
                mem_en = 1'b1;
                sys_en = 1'b1;
            end
            ST_DRAIN:   sys_en = 1'b1;
            ST_DONE:    done   = 1'b1;
            default: ;
        endcase
    end

    assign mem_wr_en = in_valid & in_ready;
    assign Ain       = in_a;
    assign Bin       = in_b;

endmodule

`default_nettype wire

// File: tb/tb_matmul_seq.sv
// ============================================================================
// Module  : tb_matmul_seq
// Purpose : Table-driven self-checking bench for matmul_seq (DRAIN=2 and DRAIN=0).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_matmul_seq;

    localparam int BITS_AB = 8;
    localparam int DIM     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start0, abort, in_valid;
    logic [DIM-1:0][BITS_AB-1:0] in_a, in_b;

    logic [DIM-1:0][BITS_AB-1:0] ain, bin, ain0, bin0;
    logic       in_ready, mem_wr_en, mem_en, sys_en, sys_clr, busy, done;
    logic [2:0] mem_row;
    logic       in_ready0, mem_wr_en0, mem_en0, sys_en0, sys_clr0, busy0, done0;
    logic [2:0] mem_row0;

    matmul_seq #(.BITS_AB(BITS_AB), .DIM(DIM), .DRAIN(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .Ain(ain), .Bin(bin), .mem_wr_en(mem_wr_en), .mem_row(mem_row),
        .mem_en(mem_en), .sys_en(sys_en), .sys_clr(sys_clr), .busy(busy), .done(done)
    );

    matmul_seq #(.BITS_AB(BITS_AB), .DIM(DIM), .DRAIN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
        .Ain(ain0), .Bin(bin0), .mem_wr_en(mem_wr_en0), .mem_row(mem_row0),
        .mem_en(mem_en0), .sys_en(sys_en0), .sys_clr(sys_clr0), .busy(busy0), .done(done0)
    );

    int checks = 0;
    int errors = 0;

    // exp bits: {in_ready, mem_en, sys_en, sys_clr, busy, done}; cycle k spans E(k)..E(k+1)
    typedef struct {
        int         tid;
        int         first;
        int         len;
        logic [5:0] exp;
    } phase_t;

    phase_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] exp_at(input int tid, input int k);
        logic [5:0] e = 6'b0;
        for (int i = 0; i < 10; i++)
            if (tbl[i].tid == tid && k >= tbl[i].first && k < tbl[i].first + tbl[i].len)
                e = tbl[i].exp;
        return e;
    endfunction

    task automatic drive_data();
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
    endtask

    // Full transaction with optional valid gap and stray start pulses at cycles k1/k2.
    task automatic run_txn(input int tid, input int gap_lo, input int gap_len,
                           input int k1, input int k2);
        int         rows;
        logic [5:0] e;
        rows = 0;
        @(posedge clk); #2;
        start = 1'b1; start0 = 1'b1; in_valid = 1'b1; drive_data();
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #2;
            start    = (k == k1) || (k == k2);
            start0   = 1'b0;
            in_valid = !(k >= gap_lo && k < gap_lo + gap_len);
            drive_data();
            #1;
            e = exp_at(tid, k);
            chk($sformatf("outs t%0d k%0d", tid, k),
                {in_ready, mem_en, sys_en, sys_clr, busy, done}, e);
            chk($sformatf("mem_wr_en k%0d", k), mem_wr_en, e[5] & in_valid);
            chk($sformatf("mem_row k%0d", k), mem_row, e[5] ? rows : 0);
            if (e[5] && in_valid) begin
                chk($sformatf("Ain k%0d", k), ain, in_a);
                chk($sformatf("Bin k%0d", k), bin, in_b);
                rows++;
            end
            chk($sformatf("d0 done k%0d", k), done0, (k == 31 + gap_len));
            chk($sformatf("d0 mem_en k%0d", k), mem_en0, (k >= 9 + gap_len && k < 31 + gap_len));
            chk($sformatf("d0 sys_en k%0d", k), sys_en0, (k >= 9 + gap_len && k < 31 + gap_len));
        end
        chk("rows written", rows, DIM);
        start = 1'b0;
    endtask

    initial begin
        // Nominal
        tbl[0] = '{0,  0,  1, 6'b000110};
        tbl[1] = '{0,  1,  8, 6'b100010};
        tbl[2] = '{0,  9, 22, 6'b011010};
        tbl[3] = '{0, 31,  2, 6'b001010};
        tbl[4] = '{0, 33,  1, 6'b000011};
        // Gap of 3 cycles after row 4
        tbl[5] = '{1,  0,  1, 6'b000110};
        tbl[6] = '{1,  1, 11, 6'b100010};
        tbl[7] = '{1, 12, 22, 6'b011010};
        tbl[8] = '{1, 34,  2, 6'b001010};
        tbl[9] = '{1, 36,  1, 6'b000011};

        rst_n = 1'b1; start = 1'b0; start0 = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset outs", {in_ready, mem_wr_en, mem_row, mem_en, sys_en, sys_clr, busy, done}, 0);
        chk("reset outs d0", {in_ready0, mem_en0, sys_en0, busy0, done0}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        run_txn(0, 100, 0, 3, 33);
        run_txn(1, 6, 3, -1, -1);

        // Abort at COMPUTE cycle 10 (k=19)
        @(posedge clk); #2;
        start = 1'b1; start0 = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #2;
            start = 1'b0; start0 = 1'b0;
            abort = (k == 19);
            #1;
            if (k == 19) chk("abort pre mem_en", {mem_en, busy}, 2'b11);
            if (k == 20) chk("abort idle", {busy, mem_en, sys_en, busy0, mem_en0}, 0);
            chk($sformatf("abort no done k%0d", k), {done, done0}, 0);
        end
        abort = 1'b0;
        run_txn(0, 100, 0, -1, -1);

        // Async reset mid-COMPUTE
        @(posedge clk); #2;
        start = 1'b1; start0 = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #2;
            start = 1'b0; start0 = 1'b0;
        end
        #1;
        chk("pre-reset compute", {mem_en, sys_en, busy}, 3'b111);
        rst_n = 1'b0;
        #1;
        chk("reset drop", {mem_en, sys_en, busy, in_ready, done}, 0);
        chk("reset drop d0", {mem_en0, sys_en0, busy0}, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        run_txn(0, 100, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
